// File: rtl/signed_sat_pkg.sv
// Shared definitions for the saturating signed add/sub datapaths.
// Provides the signed range limits as functions of the operand width
// and the saturation flag pair carried alongside each result.
package signed_sat_pkg;

  // Width the saturating arithmetic blocks are normally built at.
  localparam int SAT_DEFAULT_WIDTH = 4;

  // Saturation indication: pos = clamped to max positive, neg = clamped to min negative.
  typedef struct packed {
    logic pos;
    logic neg;
  } sat_flags_t;

  // Largest representable signed value at width w: 2^(w-1)-1.
  function automatic int sat_max(input int w);
    return (1 << (w - 1)) - 1;
  endfunction

  // Smallest representable signed value at width w: -2^(w-1).
  function automatic int sat_min(input int w);
    return -(1 << (w - 1));
  endfunction

endpackage

// File: rtl/signed_sub_sat_comb.sv
// Purpose: combinational saturating signed subtract, diff = sat(a - b).
// Latency: 0 cycles (pure combinational).
// Backpressure: none, no handshake at this level.
// Ports: a, b (signed operands) -> diff (clamped result), sat_pos / sat_neg (clamp direction).
module signed_sub_sat_comb
  import signed_sat_pkg::*;
#(
  parameter int WIDTH = SAT_DEFAULT_WIDTH
) (
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic [WIDTH-1:0] diff,
  output logic             sat_pos,
  output logic             sat_neg
);

  localparam int                MSB     = WIDTH - 1;
  localparam logic [WIDTH-1:0]  MAX_POS = WIDTH'(sat_max(WIDTH));
  localparam logic [WIDTH-1:0]  MIN_NEG = WIDTH'(sat_min(WIDTH));

  logic [WIDTH-1:0] raw;
  logic             overflow;

  // Wrapping subtract; overflow is only possible when the operand signs
  // differ, and shows up as the result sign disagreeing with the minuend.
  assign raw      = a - b;
  assign overflow = (a[MSB] != b[MSB]) && (raw[MSB] != a[MSB]);

  always_comb begin
    diff    = raw;
    sat_pos = 1'b0;
    sat_neg = 1'b0;
    if (overflow) begin
      // Minuend sign tells which rail the true result ran past.
      if (a[MSB]) begin
        diff    = MIN_NEG;
        sat_neg = 1'b1;
      end else begin
        diff    = MAX_POS;
        sat_pos = 1'b1;
      end
    end
  end

endmodule

// File: rtl/signed_sub_with_saturation_pipe.sv
// Purpose: streaming saturating signed subtractor, out = sat(a - b), with a saturation event counter.
// Latency: 2 cycles in to out, 1 result/cycle sustained.
// Backpressure: valid/ready both sides; in_ready falls only when both stages hold data and out_ready is low.
// Ports: clk, rst_n; in_valid/in_ready/a/b upstream; out_valid/out_ready/diff/sat_pos/sat_neg
//        downstream; sat_cnt (sticky saturated-delivery count), sat_cnt_clr (sync clear).
module signed_sub_with_saturation_pipe
  import signed_sat_pkg::*;
#(
  parameter int WIDTH = 4,
  parameter int CNT_W = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] diff,
  output logic             sat_pos,
  output logic             sat_neg,
  output logic [CNT_W-1:0] sat_cnt,
  input  logic             sat_cnt_clr
);

  localparam logic [CNT_W-1:0] CNT_MAX = '1;

  // Stage 1: captured operands.
  logic             s1_valid;
  logic [WIDTH-1:0] s1_a;
  logic [WIDTH-1:0] s1_b;

  // Stage 2: registered result.
  logic             s2_valid;
  logic [WIDTH-1:0] s2_diff;
  sat_flags_t       s2_flags;

  logic             s1_ready;
  logic             s2_ready;
  logic             out_xfer;

  logic [WIDTH-1:0] calc_diff;
  logic             calc_pos;
  logic             calc_neg;

  logic [CNT_W-1:0] cnt;

  // A stage can take new data when empty or when its contents leave this
  // cycle; this lets the whole pipe advance on a simultaneous in/out transfer.
  assign s2_ready = ~s2_valid | out_ready;
  assign s1_ready = ~s1_valid | s2_ready;
  assign in_ready = s1_ready;
  assign out_xfer = s2_valid & out_ready;

  signed_sub_sat_comb #(
    .WIDTH (WIDTH)
  ) u_sub (
    .a       (s1_a),
    .b       (s1_b),
    .diff    (calc_diff),
    .sat_pos (calc_pos),
    .sat_neg (calc_neg)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid <= 1'b0;
      s1_a     <= '0;
      s1_b     <= '0;
    end else if (s1_ready) begin
      s1_valid <= in_valid;
      // Operands only load on an actual transfer so idle inputs are ignored.
      if (in_valid) begin
        s1_a <= a;
        s1_b <= b;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      s2_valid <= 1'b0;
      s2_diff  <= '0;
      s2_flags <= '0;
    end else if (s2_ready) begin
      s2_valid <= s1_valid;
      if (s1_valid) begin
        s2_diff      <= calc_diff;
        s2_flags.pos <= calc_pos;
        s2_flags.neg <= calc_neg;
      end
    end
  end

  // Counts saturated results actually handed downstream; clear wins over
  // a same-cycle increment, and the count sticks at all-ones.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (sat_cnt_clr) begin
      cnt <= '0;
    end else if (out_xfer && (s2_flags.pos || s2_flags.neg) && (cnt != CNT_MAX)) begin
      cnt <= cnt + 1'b1;
    end
  end

  assign out_valid = s2_valid;
  assign diff      = s2_diff;
  assign sat_pos   = s2_flags.pos;
  assign sat_neg   = s2_flags.neg;
  assign sat_cnt   = cnt;

endmodule

// File: tb/tb_signed_sub_with_saturation_pipe.sv
// Purpose: self-checking bench for signed_sub_with_saturation_pipe (WIDTH=4, CNT_W=2).
// Latency: checks the 2-cycle in-to-out latency and full-throughput streaming.
// Backpressure: drives toggling/random out_ready and checks hold-stable and in_ready behaviour.
module tb_signed_sub_with_saturation_pipe;

  localparam int W    = 4;
  localparam int CW   = 2;
  localparam int CMAX = 3;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  diff;
  logic          sat_pos;
  logic          sat_neg;
  logic [CW-1:0] sat_cnt;
  logic          sat_cnt_clr;

  always #5 clk = ~clk;

  signed_sub_with_saturation_pipe #(
    .WIDTH (W),
    .CNT_W (CW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .in_valid    (in_valid),
    .in_ready    (in_ready),
    .a           (a),
    .b           (b),
    .out_valid   (out_valid),
    .out_ready   (out_ready),
    .diff        (diff),
    .sat_pos     (sat_pos),
    .sat_neg     (sat_neg),
    .sat_cnt     (sat_cnt),
    .sat_cnt_clr (sat_cnt_clr)
  );

  typedef struct packed {
    logic [W-1:0] d;
    logic         p;
    logic         n;
  } exp_t;

  exp_t         exp_q[$];
  logic [W-1:0] src_a[$];
  logic [W-1:0] src_b[$];

  int n_vec  = 0;
  int n_bad  = 0;
  int mcnt   = 0;
  bit mon_en = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    n_vec++;
    if (obs !== expv) begin
      n_bad++;
      $display("FAIL %s: got %0h, expected %0h at t=%0t", tag, obs, expv, $time);
    end
  endtask

  // Reference: exact integer difference clamped to the 4-bit signed range.
  function automatic exp_t ref_model(input logic [W-1:0] ra, input logic [W-1:0] rb);
    int   r;
    exp_t e;
    r   = int'($signed(ra)) - int'($signed(rb));
    e.p = (r > 7);
    e.n = (r < -8);
    if (e.p) r = 7;
    else if (e.n) r = -8;
    e.d = r[W-1:0];
    return e;
  endfunction

  // Scoreboard monitor: samples mid-cycle, i.e. the values the next rising edge will see.
  bit           prev_stall = 1'b0;
  logic [W-1:0] prev_d;
  logic         prev_p;
  logic         prev_n;

  always @(negedge clk) begin : mon
    exp_t e;
    bit   xi;
    bit   xo;
    if (!mon_en) begin
      exp_q.delete();
      mcnt       = 0;
      prev_stall = 1'b0;
    end else begin
      xi = in_valid && in_ready;
      xo = out_valid && out_ready;
      // Queue depth equals the number of occupied stages.
      check("in_ready", 32'(in_ready), 32'(!(exp_q.size() == 2 && !out_ready)));
      check("sat_cnt", 32'(sat_cnt), 32'(mcnt));
      if (prev_stall) begin
        check("hold_vld", 32'(out_valid), 32'd1);
        check("hold_diff", 32'(diff), 32'(prev_d));
        check("hold_pos", 32'(sat_pos), 32'(prev_p));
        check("hold_neg", 32'(sat_neg), 32'(prev_n));
      end
      if (out_valid) check("flags_excl", 32'(sat_pos & sat_neg), 32'd0);
      if (xo) begin
        if (exp_q.size() == 0) begin
          check("spurious_out", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          check("diff", 32'(diff), 32'(e.d));
          check("sat_pos", 32'(sat_pos), 32'(e.p));
          check("sat_neg", 32'(sat_neg), 32'(e.n));
          if (!sat_cnt_clr && (e.p || e.n) && mcnt < CMAX) mcnt++;
        end
      end
      if (sat_cnt_clr) mcnt = 0;
      if (xi) exp_q.push_back(ref_model(a, b));
      prev_stall = out_valid && !out_ready;
      prev_d     = diff;
      prev_p     = sat_pos;
      prev_n     = sat_neg;
    end
  end

  // Sends everything queued in src_a/src_b. mode 0: out_ready 1,0,1,0..;
  // mode 1: random valid/ready/clear; mode 2: out_ready always high.
  task automatic drive_all(input int mode);
    int guard = 0;
    int cyc   = 0;
    while (src_a.size() > 0 && guard < 5000) begin
      in_valid    = (mode == 1) ? ($urandom_range(0, 3) != 0) : 1'b1;
      a           = src_a[0];
      b           = src_b[0];
      out_ready   = (mode == 0) ? (cyc % 2 == 0) :
                    (mode == 1) ? ($urandom_range(0, 2) != 0) : 1'b1;
      sat_cnt_clr = (mode == 1) && ($urandom_range(0, 15) == 0);
      @(negedge clk);
      if (in_valid && in_ready) begin
        void'(src_a.pop_front());
        void'(src_b.pop_front());
      end
      @(posedge clk);
      #1;
      cyc++;
      guard++;
    end
    if (guard >= 5000) check("drive_timeout", 32'd1, 32'd0);
    in_valid    = 1'b0;
    sat_cnt_clr = 1'b0;
    out_ready   = 1'b1;
    guard       = 0;
    while (exp_q.size() > 0 && guard < 20) begin
      @(posedge clk);
      #1;
      guard++;
    end
    check("drain_empty", 32'(exp_q.size()), 32'd0);
  endtask

  // Single transaction into an empty pipe: invisible after the first edge, out after the second.
  task automatic lat_test(input logic [W-1:0] ta, input logic [W-1:0] tb_v, input string tag);
    exp_t e;
    e         = ref_model(ta, tb_v);
    in_valid  = 1'b1;
    a         = ta;
    b         = tb_v;
    out_ready = 1'b1;
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    check({tag, "_vld_e0"}, 32'(out_valid), 32'd0);
    @(posedge clk);
    #1;
    check({tag, "_vld_e1"}, 32'(out_valid), 32'd1);
    check({tag, "_diff"}, 32'(diff), 32'(e.d));
    check({tag, "_pos"}, 32'(sat_pos), 32'(e.p));
    check({tag, "_neg"}, 32'(sat_neg), 32'(e.n));
  endtask

  task automatic push_pair(input logic [W-1:0] pa, input logic [W-1:0] pb);
    src_a.push_back(pa);
    src_b.push_back(pb);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst_n       = 1'b0;
    in_valid    = 1'b0;
    a           = '0;
    b           = '0;
    out_ready   = 1'b0;
    sat_cnt_clr = 1'b0;
    #12;
    check("rst_vld", 32'(out_valid), 32'd0);
    check("rst_diff", 32'(diff), 32'd0);
    check("rst_flags", 32'({sat_pos, sat_neg}), 32'd0);
    check("rst_cnt", 32'(sat_cnt), 32'd0);
    @(posedge clk);
    #3;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    @(posedge clk);
    #1;

    // Directed arithmetic and latency.
    lat_test(4'd3, 4'hA, "a3_bm6");
    @(posedge clk);
    #1;
    check("cnt_after_first_sat", 32'(sat_cnt), 32'd1);
    lat_test(4'hB, 4'd4, "am5_b4");
    lat_test(4'd3, 4'd2, "a3_b2");
    lat_test(4'd0, 4'h8, "a0_bm8");
    @(posedge clk);
    #1;

    // 8 back-to-back pairs with out_ready toggling.
    for (int i = 0; i < 8; i++) push_pair(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    drive_all(0);

    // Exhaustive operand sweep.
    for (int i = 0; i < 16; i++)
      for (int j = 0; j < 16; j++) push_pair(4'(i), 4'(j));
    drive_all(2);

    // Random traffic with random backpressure and clears.
    for (int i = 0; i < 300; i++) push_pair(4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)));
    drive_all(1);

    // Counter stickiness: clear, then five saturating results -> 1,2,3,3,3.
    sat_cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_cnt_clr = 1'b0;
    check("cnt_cleared", 32'(sat_cnt), 32'd0);
    for (int i = 0; i < 5; i++) begin
      if (i % 2 == 0) push_pair(4'd3, 4'hA);
      else push_pair(4'hB, 4'd4);
    end
    drive_all(2);
    check("cnt_sticky", 32'(sat_cnt), 32'(CMAX));

    // Fill both stages under stall, then reset asynchronously.
    in_valid  = 1'b1;
    a         = 4'd3;
    b         = 4'hA;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    check("full_in_ready", 32'(in_ready), 32'd0);
    mon_en = 1'b0;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_vld", 32'(out_valid), 32'd0);
    check("arst_cnt", 32'(sat_cnt), 32'd0);
    check("arst_diff", 32'(diff), 32'd0);
    out_ready = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      check("arst_no_out", 32'(out_valid), 32'd0);
    end
    in_valid = 1'b0;
    @(posedge clk);
    #3;
    rst_n  = 1'b1;
    mon_en = 1'b1;
    lat_test(4'd0, 4'h8, "post_rst");
    @(posedge clk);
    #1;
    check("post_rst_cnt", 32'(sat_cnt), 32'd1);

    // Clear coincident with a saturating output transfer.
    in_valid  = 1'b1;
    a         = 4'd3;
    b         = 4'hA;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    in_valid    = 1'b0;
    out_ready   = 1'b1;
    sat_cnt_clr = 1'b1;
    @(posedge clk);
    #1;
    sat_cnt_clr = 1'b0;
    check("clr_on_sat_xfer", 32'(sat_cnt), 32'd0);
    @(posedge clk);
    #1;
    check("cnt_after_clr_xfer", 32'(sat_cnt), 32'd1);
    @(posedge clk);
    #1;
    check("final_drain", 32'(exp_q.size()), 32'd0);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
